// File: rtl/alu_nibble_sequencer.sv
// Sequences a 32-bit MIPS ALU op through one external 4-bit slice, one nibble per cycle.
// Define ALU_OVF_DETECT_EN to add the ovf output and a signed-correct slt.
module alu_nibble_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero,
  output logic        cout,
  output logic        invalid,
`ifdef ALU_OVF_DETECT_EN
  output logic        ovf,
`endif
  output logic [3:0]  s_a,
  output logic [3:0]  s_b,
  output logic        s_cin,
  output logic        s_binv,
  output logic        s_sel1,
  output logic        s_sel0,
  output logic [3:0]  s_less,
  input  logic [3:0]  s_result,
  input  logic        s_co
);

  localparam int unsigned NIBBLES = 8;
  localparam logic [2:0]  LAST_K  = 3'(NIBBLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_BAD} op_t;

  state_t      state;
  op_t         op_q;
  op_t         op_dec;
  logic [2:0]  k;
  logic [2:0]  kn;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [27:0] res_q;
  logic [1:0]  dec_sel;
  logic        dec_binv;
  logic        arith_q;
  logic        set_bit;
  logic [31:0] fin;
`ifdef ALU_OVF_DETECT_EN
  logic        ovf_w;
`endif

  assign s_less = '0;

  always_comb begin
    op_dec = OP_BAD;
    case (alu_op)
      2'b00: op_dec = OP_ADD;
      2'b01: op_dec = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100000: op_dec = OP_ADD;
          6'b100010: op_dec = OP_SUB;
          6'b100100: op_dec = OP_AND;
          6'b100101: op_dec = OP_OR;
          6'b101010: op_dec = OP_SLT;
          default:   op_dec = OP_BAD;
        endcase
      end
      default: op_dec = OP_BAD;
    endcase
  end

  always_comb begin
    dec_sel  = 2'b00;
    dec_binv = 1'b0;
    case (op_dec)
      OP_ADD:         begin dec_sel = 2'b10; dec_binv = 1'b0; end
      OP_SUB, OP_SLT: begin dec_sel = 2'b10; dec_binv = 1'b1; end
      OP_AND:         begin dec_sel = 2'b00; dec_binv = 1'b0; end
      OP_OR:          begin dec_sel = 2'b01; dec_binv = 1'b0; end
      default:        begin dec_sel = 2'b00; dec_binv = 1'b0; end
    endcase
  end

  // Final-pass view: the top nibble is still on s_result when the result is registered.
  always_comb begin
    kn      = k + 3'd1;
    arith_q = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
`ifdef ALU_OVF_DETECT_EN
    ovf_w   = (a_q[31] == (b_q[31] ^ s_binv)) && (s_result[3] != a_q[31]);
    set_bit = s_result[3] ^ ovf_w;
`else
    set_bit = s_result[3];
`endif
    fin = (op_q == OP_SLT) ? {31'b0, set_bit} : {s_result, res_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_ADD;
      k       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b0;
      cout    <= 1'b0;
      invalid <= 1'b0;
`ifdef ALU_OVF_DETECT_EN
      ovf     <= 1'b0;
`endif
      s_a     <= '0;
      s_b     <= '0;
      s_cin   <= 1'b0;
      s_binv  <= 1'b0;
      s_sel1  <= 1'b0;
      s_sel0  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            invalid <= 1'b0;
            op_q    <= op_dec;
            if (op_dec == OP_BAD) begin
              result  <= '0;
              zero    <= 1'b1;
              cout    <= 1'b0;
              invalid <= 1'b1;
`ifdef ALU_OVF_DETECT_EN
              ovf     <= 1'b0;
`endif
              done    <= 1'b1;
              state   <= ST_DONE;
            end else begin
              a_q    <= a;
              b_q    <= b;
              k      <= '0;
              s_a    <= a[3:0];
              s_b    <= b[3:0];
              s_cin  <= dec_binv;
              s_binv <= dec_binv;
              s_sel1 <= dec_sel[1];
              s_sel0 <= dec_sel[0];
              state  <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (k == LAST_K) begin
            result <= fin;
            zero   <= (fin == '0);
            cout   <= arith_q ? s_co : 1'b0;
`ifdef ALU_OVF_DETECT_EN
            ovf    <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? ovf_w : 1'b0;
`endif
            done   <= 1'b1;
            s_a    <= '0;
            s_b    <= '0;
            s_cin  <= 1'b0;
            s_binv <= 1'b0;
            s_sel1 <= 1'b0;
            s_sel0 <= 1'b0;
            state  <= ST_DONE;
          end else begin
            // Low nibbles shift in from the top; after seven passes nibble 0 sits at [3:0].
            res_q <= {s_result, res_q[27:4]};
            s_cin <= s_co;
            s_a   <= a_q[{kn, 2'b00} +: 4];
            s_b   <= b_q[{kn, 2'b00} +: 4];
            k     <= kn;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: behavioural 4-bit slice, cycle-level output model
// and directed ops with hand-computed expectations.
module tb_alu_nibble_sequencer;

`ifdef ALU_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, zero, cout, invalid, ovf;
  logic [31:0] result;
  logic [3:0]  s_a, s_b, s_less, s_result;
  logic        s_cin, s_binv, s_sel1, s_sel0, s_co;
  logic [3:0]  bb;
  logic [4:0]  sum;

`ifndef ALU_OVF_DETECT_EN
  assign ovf = 1'b0;
`endif

  alu_nibble_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .funct(funct),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero),
    .cout(cout), .invalid(invalid),
`ifdef ALU_OVF_DETECT_EN
    .ovf(ovf),
`endif
    .s_a(s_a), .s_b(s_b), .s_cin(s_cin), .s_binv(s_binv), .s_sel1(s_sel1),
    .s_sel0(s_sel0), .s_less(s_less), .s_result(s_result), .s_co(s_co)
  );

  always #5 clk = ~clk;

  // External MIPS 4-bit ALU slice
  always_comb begin
    bb   = s_binv ? ~s_b : s_b;
    sum  = {1'b0, s_a} + {1'b0, bb} + {4'b0, s_cin};
    s_co = sum[4];
    case ({s_sel1, s_sel0})
      2'b00:   s_result = s_a & bb;
      2'b01:   s_result = s_a | bb;
      2'b10:   s_result = sum[3:0];
      default: s_result = s_less;
    endcase
  end

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int m_acc = -100;
  int m_dn = -100;
  int n_dones = 0;

  typedef struct packed {
    logic        inv;
    logic [1:0]  sel;
    logic        binv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        cout;
    logic        ovf;
  } exp_t;
  exp_t p;

  function automatic bit is_invalid(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00 || op == 2'b01) return 1'b0;
    if (op == 2'b10)
      return !(fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
    return 1'b1;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int kind;
    logic [32:0] s;
    longint sx, sy, v;
    e = '0;
    e.a = x;
    e.b = y;
    kind = 5;
    if (op == 2'b00) kind = 0;
    else if (op == 2'b01) kind = 1;
    else if (op == 2'b10) begin
      case (fn)
        6'h20: kind = 0;
        6'h22: kind = 1;
        6'h24: kind = 2;
        6'h25: kind = 3;
        6'h2A: kind = 4;
        default: kind = 5;
      endcase
    end
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (kind)
      0: begin
        s = {1'b0, x} + {1'b0, y};
        v = sx + sy;
        e.sel = 2'b10; e.res = s[31:0]; e.cout = s[32];
        e.ovf = OVF_EN && (v > 64'sd2147483647 || v < -64'sd2147483648);
      end
      1: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        v = sx - sy;
        e.sel = 2'b10; e.binv = 1'b1; e.res = s[31:0]; e.cout = s[32];
        e.ovf = OVF_EN && (v > 64'sd2147483647 || v < -64'sd2147483648);
      end
      2: begin e.sel = 2'b00; e.res = x & y; end
      3: begin e.sel = 2'b01; e.res = x | y; end
      4: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        e.sel = 2'b10; e.binv = 1'b1; e.cout = s[32];
        e.res = {31'b0, OVF_EN ? (sx < sy) : s[31]};
      end
      default: e.inv = 1'b1;
    endcase
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  // Expected slice-side signals for nibble pass j: carry-in is the true carry into bit 4j.
  function automatic logic [15:0] exp_slice(input int j, input exp_t e);
    logic [32:0] t, msk;
    logic [31:0] bx;
    bx  = e.binv ? ~e.b : e.b;
    msk = (33'd1 << (4 * j)) - 33'd1;
    t   = ({1'b0, e.a} & msk) + ({1'b0, bx} & msk) + {32'b0, e.binv};
    return {e.a[4*j +: 4], e.b[4*j +: 4], t[4*j], e.binv, e.sel, 4'b0000};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc <= -100;
      m_dn  <= -100;
      p     <= '0;
    end else if (start && cyc > m_dn) begin
      p     <= model(alu_op, funct, a, b);
      m_acc <= cyc + 1;
      m_dn  <= cyc + 1 + (is_invalid(alu_op, funct) ? 0 : 8);
    end
  end

  always @(negedge clk) if (done) n_dones <= n_dones + 1;

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'((cyc >= m_acc) && (cyc <= m_dn)));
      chk("done", 32'(done), 32'(cyc == m_dn));
      if (cyc >= m_dn) begin
        chk("result", result, p.res);
        chk("zero", 32'(zero), 32'(p.zero));
        chk("cout", 32'(cout), 32'(p.cout));
        chk("invalid", 32'(invalid), 32'(p.inv));
`ifdef ALU_OVF_DETECT_EN
        chk("ovf", 32'(ovf), 32'(p.ovf));
`endif
      end else begin
        chk("invalid_run", 32'(invalid), 32'h0);
      end
      chk("slice_io", 32'({s_a, s_b, s_cin, s_binv, s_sel1, s_sel0, s_less}),
          32'((cyc >= m_acc && cyc < m_dn) ? exp_slice(cyc - m_acc, p) : 16'h0));
    end
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; alu_op = op; funct = fn; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    alu_op = 2'($urandom); funct = 6'($urandom);
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) begin
      n_total++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", lat);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    logic        z;
    logic        c;
    int          lat;
  } vec_t;
  vec_t vt[10];

  initial begin
    int lat;
    int d0;
    #100000;
    $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    int d0;
    vt[0] = '{2'b00, 6'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 9};
    vt[1] = '{2'b01, 6'h00, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 9};
    vt[2] = '{2'b10, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 9};
    vt[3] = '{2'b10, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 9};
    vt[4] = '{2'b10, 6'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 9};
    vt[5] = '{2'b10, 6'h2A, 32'h80000000, 32'h00000001, 32'(OVF_EN), !OVF_EN, 1'b1, 9};
    vt[6] = '{2'b10, 6'h00, 32'h12345678, 32'h11111111, 32'h00000000, 1'b1, 1'b0, 1};
    vt[7] = '{2'b11, 6'h20, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
    vt[8] = '{2'b10, 6'h22, 32'h12345678, 32'h9ABCDEF0, 32'h77777788, 1'b0, 1'b0, 9};
    vt[9] = '{2'b10, 6'h20, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 9};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'h0);
    chk("rst_slice", 32'({s_a, s_b, s_cin, s_binv, s_sel1, s_sel0}), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(vt[i].op, vt[i].fn, vt[i].x, vt[i].y);
      wait_done(1, lat);
      chk($sformatf("lit_result_%0d", i), result, vt[i].r);
      chk($sformatf("lit_zero_%0d", i), 32'(zero), 32'(vt[i].z));
      chk($sformatf("lit_cout_%0d", i), 32'(cout), 32'(vt[i].c));
      chk($sformatf("lit_latency_%0d", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("lit_invalid_%0d", i), 32'(invalid), 32'(vt[i].lat == 1));
`ifdef ALU_OVF_DETECT_EN
      if (i == 0) chk("lit_ovf_add", 32'(ovf), 32'h1);
      if (i == 1) chk("lit_ovf_sub", 32'(ovf), 32'h0);
`endif
    end

    // start raised during the done cycle must not be accepted
    issue(2'b11, 6'h00, 32'h1, 32'h2);
    wait_done(1, lat);
    start = 1'b1; alu_op = 2'b00; a = 32'h1; b = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_busy", 32'(busy), 32'h0);

    // re-pulse at cycle 3 while busy
    d0 = n_dones;
    issue(2'b00, 6'h00, 32'h3, 32'h4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; alu_op = 2'b01; a = 32'd100; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(4, lat);
    chk("repulse_latency", 32'(lat), 32'd9);
    chk("repulse_result", result, 32'h7);
    repeat (12) @(posedge clk);
    #1;
    chk("repulse_single_done", 32'(n_dones - d0), 32'h1);

    // reset at cycle 4 of an op
    issue(2'b10, 6'h22, 32'hDEADBEEF, 32'h01234567);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_slice", 32'({s_a, s_b, s_cin, s_binv, s_sel1, s_sel0}), 32'h0);
    d0 = n_dones;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(n_dones - d0), 32'h0);

    issue(2'b00, 6'h00, 32'h10, 32'h20);
    wait_done(1, lat);
    chk("post_rst_result", result, 32'h30);
    chk("post_rst_latency", 32'(lat), 32'd9);
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
